// File: rtl/dsd_mem_pkg.sv
// Shared definitions for the D-side memory path: line geometry, write-buffer
// FSM state and buffered-entry layout.
package dsd_mem_pkg;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned LINE_ADDR_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MWR,
        ST_MRD,
        ST_RESP
    } wb_state_e;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] addr;
        logic [LINE_W-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_line_fifo.sv
// Circular line FIFO for the D-cache write buffer, with per-entry address match
// and youngest-match select. Forwarded read data exists only with WB_READ_FWD_EN.
module wbuf_line_fifo
    import dsd_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   coalesce,
    input  logic [LINE_ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0]      req_data,
    output logic                   hit,
`ifdef WB_READ_FWD_EN
    output logic [LINE_W-1:0]      hit_data,
`endif
    output wb_entry_t              head_entry,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] hit_idx;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] match;

    // A slot is valid when its distance from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        logic [PTR_W-1:0] age;
        assign age      = PTR_W'(g) - head;
        assign match[g] = ({1'b0, age} < count_q) && (entries[g].addr == req_addr);
    end

    // Walk oldest to youngest so the last match seen wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (match[head + PTR_W'(k)]) begin
                hit     = 1'b1;
                hit_idx = head + PTR_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: req_addr, data: req_data};
        end else if (coalesce) begin
            entries[hit_idx].data <= req_data;
        end
    end

    assign head_entry = entries[head];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
`ifdef WB_READ_FWD_EN
    assign hit_data   = entries[hit_idx].data;
`endif

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the D-cache and slow data memory; drains in the
// background and keeps reads ordered. WB_READ_FWD_EN enables read forwarding.
module dcache_write_buffer
    import dsd_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   c_read,
    input  logic                   c_write,
    input  logic [LINE_ADDR_W-1:0] c_addr,
    input  logic [LINE_W-1:0]      c_wdata,
    output logic [LINE_W-1:0]      c_rdata,
    output logic                   c_ready,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [LINE_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic                   wb_empty
);

    wb_state_e state;
    wb_entry_t head_entry;
    logic      hit, full, empty;
    logic      push, pop, coalesce, drain, go_mrd;
`ifdef WB_READ_FWD_EN
    logic [LINE_W-1:0] hit_data;
    logic              fwd_hit;
`endif

    wbuf_line_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (proc_reset),
        .push       (push),
        .pop        (pop),
        .coalesce   (coalesce),
        .req_addr   (c_addr),
        .req_data   (c_wdata),
        .hit        (hit),
`ifdef WB_READ_FWD_EN
        .hit_data   (hit_data),
`endif
        .head_entry (head_entry),
        .full       (full),
        .empty      (empty)
    );

    // IDLE arbitration: read, then write, then background drain.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        coalesce = 1'b0;
        drain    = 1'b0;
        go_mrd   = 1'b0;
`ifdef WB_READ_FWD_EN
        fwd_hit  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (c_read) begin
`ifdef WB_READ_FWD_EN
                    if (hit) fwd_hit = 1'b1;
                    else     go_mrd  = 1'b1;
`else
                    if (empty) go_mrd = 1'b1;
                    else       drain  = 1'b1;
`endif
                end else if (c_write) begin
                    if (hit)        coalesce = 1'b1;
                    else if (!full) push     = 1'b1;
                    else            drain    = 1'b1;
                end else if (!empty) begin
                    drain = 1'b1;
                end
            end
            ST_MWR:  pop = mem_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= ST_IDLE;
            c_ready   <= 1'b0;
            c_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            c_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drain) begin
                        mem_write <= 1'b1;
                        mem_addr  <= head_entry.addr;
                        mem_wdata <= head_entry.data;
                        state     <= ST_MWR;
                    end else if (go_mrd) begin
                        mem_read <= 1'b1;
                        mem_addr <= c_addr;
                        state    <= ST_MRD;
                    end else if (push || coalesce) begin
                        c_ready <= 1'b1;
                        state   <= ST_RESP;
                    end
`ifdef WB_READ_FWD_EN
                    if (fwd_hit) begin
                        c_rdata <= hit_data;
                        c_ready <= 1'b1;
                        state   <= ST_RESP;
                    end
`endif
                end
                ST_MWR: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_MRD: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        c_rdata  <= mem_rdata;
                        c_ready  <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wb_empty = empty & (state != ST_MWR);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer; expectations follow WB_READ_FWD_EN.
module tb_dcache_write_buffer;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         c_read, c_write;
    logic [27:0]  c_addr;
    logic [127:0] c_wdata, c_rdata;
    logic         c_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic         wb_empty;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned lat    = 3;
    int unsigned mcnt   = 0;

    typedef struct {
        logic         is_rd;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    mem_txn_t     log_q[$];
    logic [127:0] store [logic [27:0]];

    localparam logic [127:0] DA = {4{32'hA0A0_A0A1}};
    localparam logic [127:0] DB = {4{32'hB0B0_B0B2}};
    localparam logic [127:0] DC = {4{32'hC0C0_C0C3}};
    localparam logic [127:0] DE = {4{32'hE0E0_E0E4}};
    localparam logic [127:0] DF = {4{32'hF0F0_F0F5}};
    localparam logic [127:0] DX = {4{32'h1234_5678}};

    dcache_write_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .c_read     (c_read),
        .c_write    (c_write),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rdata    (c_rdata),
        .c_ready    (c_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .wb_empty   (wb_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] default_line(input logic [27:0] a);
        return {4{4'hD, a}};
    endfunction

    // Slow memory: answers after lat cycles with a one-cycle mem_ready.
    always @(negedge clk) begin
        if (proc_reset) begin
            mem_ready = 1'b0;
            mcnt      = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mcnt      = 0;
        end else if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt >= lat) begin
                mem_ready = 1'b1;
                if (mem_read) begin
                    mem_rdata = store.exists(mem_addr) ? store[mem_addr] : default_line(mem_addr);
                    log_q.push_back('{1'b1, mem_addr, mem_rdata});
                end else begin
                    store[mem_addr] = mem_wdata;
                    log_q.push_back('{1'b0, mem_addr, mem_wdata});
                end
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cache_req(input logic rd, input logic [27:0] a, input logic [127:0] d,
                             output int unsigned cyc, output logic [127:0] rdata);
        @(posedge clk);
        @(negedge clk);
        c_read  = rd;
        c_write = ~rd;
        c_addr  = a;
        c_wdata = d;
        cyc     = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!c_ready && cyc < 400);
        check("req_ready", 128'(c_ready), 128'(1));
        rdata   = c_rdata;
        c_read  = 1'b0;
        c_write = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (wb_empty) break;
        end
        check(tag, 128'(wb_empty), 128'(1));
    endtask

    task automatic check_txn(input string tag, input int unsigned idx, input logic rd,
                             input logic [27:0] a, input logic [127:0] d);
        mem_txn_t t;
        t = (idx < log_q.size()) ? log_q[idx] : '{1'bx, 28'hx, 128'hx};
        check({tag, "_kind"}, 128'(t.is_rd), 128'(rd));
        check({tag, "_addr"}, 128'(t.addr), 128'(a));
        check({tag, "_data"}, t.data, d);
    endtask

    initial begin
        int unsigned  cyc;
        logic [127:0] rd;

        proc_reset = 1'b1;
        c_read     = 1'b0;
        c_write    = 1'b0;
        c_addr     = '0;
        c_wdata    = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        #1;
        check("rst_c_ready",   128'(c_ready),   128'(0));
        check("rst_c_rdata",   c_rdata,         128'(0));
        check("rst_mem_read",  128'(mem_read),  128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr",  128'(mem_addr),  128'(0));
        check("rst_mem_wdata", mem_wdata,       128'(0));
        check("rst_wb_empty",  128'(wb_empty),  128'(1));
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;

        // Single posted write, then background drain.
        lat = 3;
        cache_req(1'b0, 28'h0000010, DA, cyc, rd);
        check("w1_lat", 128'(cyc), 128'(1));
        check("w1_not_empty", 128'(wb_empty), 128'(0));
        wait_empty("w1_empty");
        check("w1_log_size", 128'(log_q.size()), 128'(1));
        check_txn("w1_txn", 0, 1'b0, 28'h0000010, DA);
        log_q.delete();

        // Five writes into a 4-deep buffer with slow memory.
        lat = 8;
        for (int unsigned i = 0; i < 5; i++) begin
            cache_req(1'b0, 28'h100 + 28'(i), {4{32'hC0DE_0000 + i}}, cyc, rd);
            check($sformatf("fill%0d_lat", i), 128'(cyc), (i < 4) ? 128'(1) : 128'(10));
        end
        wait_empty("fill_empty");
        check("fill_log_size", 128'(log_q.size()), 128'(5));
        for (int unsigned i = 0; i < 5; i++) begin
            check_txn($sformatf("fill%0d_txn", i), i, 1'b0, 28'h100 + 28'(i), {4{32'hC0DE_0000 + i}});
        end
        log_q.delete();

        // Coalescing a rewrite of 0x20 while 0x10 is draining.
        lat = 3;
        cache_req(1'b0, 28'h10, DX, cyc, rd);
        cache_req(1'b0, 28'h20, DA, cyc, rd);
        for (int i = 0; i < 100 && !mem_write; i++) @(negedge clk);
        check("co_drain_on", 128'(mem_write), 128'(1));
        check("co_drain_addr", 128'(mem_addr), 128'(28'h10));
        cache_req(1'b0, 28'h20, DB, cyc, rd);
        wait_empty("co_empty");
        check("co_log_size", 128'(log_q.size()), 128'(2));
        check_txn("co_txn0", 0, 1'b0, 28'h10, DX);
        check_txn("co_txn1", 1, 1'b0, 28'h20, DB);
        log_q.delete();

        // Read-after-write of 0x30.
        cache_req(1'b0, 28'h30, DC, cyc, rd);
        cache_req(1'b1, 28'h30, '0, cyc, rd);
        check("raw_rdata", rd, DC);
`ifdef WB_READ_FWD_EN
        check("raw_lat", 128'(cyc), 128'(1));
        wait_empty("raw_empty");
        check("raw_log_size", 128'(log_q.size()), 128'(1));
        check_txn("raw_txn0", 0, 1'b0, 28'h30, DC);
`else
        check("raw_lat", 128'(cyc), 128'(8));
        wait_empty("raw_empty");
        check("raw_log_size", 128'(log_q.size()), 128'(2));
        check_txn("raw_txn0", 0, 1'b0, 28'h30, DC);
        check_txn("raw_txn1", 1, 1'b1, 28'h30, DC);
`endif
        log_q.delete();

        // Read miss of 0x50 with 0x40 still buffered.
        cache_req(1'b0, 28'h40, DE, cyc, rd);
        cache_req(1'b1, 28'h50, '0, cyc, rd);
        check("miss_rdata", rd, default_line(28'h50));
        wait_empty("miss_empty");
        check("miss_log_size", 128'(log_q.size()), 128'(2));
`ifdef WB_READ_FWD_EN
        check("miss_lat", 128'(cyc), 128'(4));
        check_txn("miss_txn0", 0, 1'b1, 28'h50, default_line(28'h50));
        check_txn("miss_txn1", 1, 1'b0, 28'h40, DE);
`else
        check("miss_lat", 128'(cyc), 128'(8));
        check_txn("miss_txn0", 0, 1'b0, 28'h40, DE);
        check_txn("miss_txn1", 1, 1'b1, 28'h50, default_line(28'h50));
`endif
        log_q.delete();

        // Reset in the middle of a drain.
        lat = 50;
        cache_req(1'b0, 28'h60, DF, cyc, rd);
        for (int i = 0; i < 100 && !mem_write; i++) @(negedge clk);
        check("rmid_drain_on", 128'(mem_write), 128'(1));
        @(posedge clk);
        #2;
        proc_reset = 1'b1;
        #1;
        check("rmid_mem_write", 128'(mem_write), 128'(0));
        check("rmid_wb_empty", 128'(wb_empty), 128'(1));
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rmid_no_redrain", 128'(mem_write), 128'(0));
        check("rmid_still_empty", 128'(wb_empty), 128'(1));
        check("rmid_log_size", 128'(log_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
